// File: rtl/statemachine.sv
// Moore controller that steps the baccarat datapath through one hand: four
// opening deals, the third-card rules, then the winner lights.
module statemachine (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] state_out
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 4'd0,
        DP1    = 4'd1,
        DD1    = 4'd2,
        DP2    = 4'd3,
        DD2    = 4'd4,
        EVAL_P = 4'd5,
        DP3    = 4'd6,
        EVAL_D = 4'd7,
        DD3    = 4'd8,
        DONE   = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] pcard3_val;
    logic       natural;
    logic       dealer_draw;

    // Face cards and tens count as zero toward the dealer's third-card decision.
    assign pcard3_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
    assign natural    = (pscore >= 4'd8) || (dscore >= 4'd8);

    always_comb begin
        dealer_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
            4'd3:             dealer_draw = (pcard3_val != 4'd8);
            4'd4:             dealer_draw = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
            4'd5:             dealer_draw = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
            4'd6:             dealer_draw = (pcard3_val >= 4'd6) && (pcard3_val <= 4'd7);
            default:          dealer_draw = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = DP1;
            DP1:    state_d = DD1;
            DD1:    state_d = DP2;
            DP2:    state_d = DD2;
            DD2:    state_d = EVAL_P;
            EVAL_P: begin
                if (natural)                state_d = DONE;
                else if (pscore <= 4'd5)    state_d = DP3;
                else if (dscore <= 4'd5)    state_d = DD3;
                else                        state_d = DONE;
            end
            DP3:    state_d = EVAL_D;
            EVAL_D: state_d = dealer_draw ? DD3 : DONE;
            DD3:    state_d = DONE;
            DONE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Outputs decode the state register directly so reset clears them without an edge.
    assign state_out        = state_q;
    assign load_pcard1      = (state_q == DP1);
    assign load_dcard1      = (state_q == DD1);
    assign load_pcard2      = (state_q == DP2);
    assign load_dcard2      = (state_q == DD2);
    assign load_pcard3      = (state_q == DP3);
    assign load_dcard3      = (state_q == DD3);
    assign player_win_light = (state_q == DONE) && (pscore >= dscore);
    assign dealer_win_light = (state_q == DONE) && (dscore >= pscore);

endmodule
